// File: rtl/packet_monitor.sv
// Receive-side checker for the packet generator's AXI Stream output: classifies each
// frame by destination MAC, checks it against its flow and keeps saturating per-flow stats.
module packet_monitor #(
  parameter int DATA_WIDTH = 512,
  parameter int N_FLOWS = 4,
  parameter logic [N_FLOWS*11-1:0] SIZES = {4{11'd192}},
  parameter logic [N_FLOWS*48-1:0] D_MACS = {48'hABCDEF000004, 48'hABCDEF000003,
                                             48'hABCDEF000002, 48'hABCDEF000001},
  parameter logic [N_FLOWS*48-1:0] S_MACS = {48'hBEEFBEEF0004, 48'hBEEFBEEF0003,
                                             48'hBEEFBEEF0002, 48'hBEEFBEEF0001},
  parameter logic [N_FLOWS*16-1:0] ETHERTYPES = {4{16'h0800}},
  parameter logic [N_FLOWS*8-1:0] PAYLOADS = {8'hDD, 8'hCC, 8'hBB, 8'hAA},
  localparam int KEEP_W = DATA_WIDTH / 8,
  localparam int SEL_W = (N_FLOWS > 1) ? $clog2(N_FLOWS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  axis_tvalid,
  input  logic                  axis_tlast,
  input  logic [KEEP_W-1:0]     axis_tkeep,
  input  logic [DATA_WIDTH-1:0] axis_tdata,
  input  logic                  stat_clear,
  input  logic [SEL_W-1:0]      stat_sel,
  output logic [31:0]           stat_pkt_count,
  output logic [47:0]           stat_byte_count,
  output logic [31:0]           stat_err_count,
  output logic [31:0]           stat_unmatched,
  output logic                  pkt_done,
  output logic [SEL_W-1:0]      pkt_flow,
  output logic [4:0]            pkt_err_flags
);

  typedef enum logic {HEAD, BODY} state_t;

  function automatic logic [15:0] popcount(input logic [KEEP_W-1:0] v);
    logic [15:0] n;
    n = '0;
    for (int i = 0; i < KEEP_W; i++) n = n + 16'(v[i]);
    return n;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] a);
    return (a == 32'hFFFF_FFFF) ? a : a + 32'd1;
  endfunction

  function automatic logic [47:0] sat_add48(input logic [47:0] a, input logic [15:0] b);
    logic [48:0] s;
    s = {1'b0, a} + {33'd0, b};
    return s[48] ? 48'hFFFF_FFFF_FFFF : s[47:0];
  endfunction

  state_t            state;
  logic [47:0]       d_mac;
  logic [47:0]       s_mac;
  logic [15:0]       ethertype;
  logic              hit;
  logic [SEL_W-1:0]  hit_flow;

  logic [SEL_W-1:0]  flow_p0;
  logic              match_p0;
  logic [15:0]       total_p0;
  logic              hdr_p0;
  logic              pay_p0;
  logic              keep_p0;

  logic              in_head;
  logic [SEL_W-1:0]  cur_flow;
  logic              cur_match;
  logic [15:0]       cur_total;
  logic              cur_hdr;
  logic              cur_pay;
  logic              cur_keep;
  logic [7:0]        fill;
  logic              hdr_bad;
  logic              beat_pay_bad;
  logic              beat_keep_bad;
  logic [KEEP_W-1:0] keep_inc;
  logic [10:0]       exp_size;
  logic              runt;
  logic [4:0]        end_flags;

  logic              vld_p1;
  logic [SEL_W-1:0]  flow_p1;
  logic              match_p1;
  logic [15:0]       total_p1;
  logic [4:0]        flags_p1;

  logic [31:0]       pkt_cnt  [N_FLOWS];
  logic [47:0]       byte_cnt [N_FLOWS];
  logic [31:0]       err_cnt  [N_FLOWS];
  logic [31:0]       unmatched_cnt;

  // Header fields: byte 0 on the wire is the MSB of each field.
  always_comb begin
    d_mac = '0;
    s_mac = '0;
    for (int i = 0; i < 6; i++) begin
      d_mac[47-8*i -: 8] = axis_tdata[8*i +: 8];
      s_mac[47-8*i -: 8] = axis_tdata[8*(i+6) +: 8];
    end
    ethertype = {axis_tdata[8*12 +: 8], axis_tdata[8*13 +: 8]};
  end

  // Descending scan so the lowest matching flow index is the one left standing.
  always_comb begin
    hit = 1'b0;
    hit_flow = '0;
    for (int i = N_FLOWS - 1; i >= 0; i--) begin
      if (d_mac == D_MACS[i*48 +: 48]) begin
        hit = 1'b1;
        hit_flow = SEL_W'(i);
      end
    end
  end

  // Stage p0: fold the current beat into the running per-frame totals and sticky flags.
  always_comb begin
    in_head   = (state == HEAD);
    cur_flow  = in_head ? hit_flow : flow_p0;
    cur_match = in_head ? hit : match_p0;
    fill      = PAYLOADS[cur_flow*8 +: 8];
    hdr_bad   = (s_mac != S_MACS[hit_flow*48 +: 48]) ||
                (ethertype != ETHERTYPES[hit_flow*16 +: 16]);
    beat_pay_bad = 1'b0;
    for (int k = 0; k < KEEP_W; k++) begin
      if (axis_tkeep[k] && (!in_head || k >= 14) && (axis_tdata[8*k +: 8] != fill))
        beat_pay_bad = 1'b1;
    end
    keep_inc = axis_tkeep + KEEP_W'(1);
    if (axis_tlast)
      beat_keep_bad = (axis_tkeep == '0) || ((axis_tkeep & keep_inc) != '0);
    else
      beat_keep_bad = (axis_tkeep != '1);
    cur_total = sat_add16(in_head ? 16'd0 : total_p0, popcount(axis_tkeep));
    cur_hdr   = in_head ? hdr_bad : hdr_p0;
    cur_pay   = (!in_head && pay_p0) || beat_pay_bad;
    cur_keep  = (!in_head && keep_p0) || beat_keep_bad;
    exp_size  = SIZES[cur_flow*11 +: 11];
    runt      = (cur_total < 16'd14);
    end_flags = {cur_keep, runt, (cur_total != {5'd0, exp_size}),
                 cur_pay && !runt, cur_hdr && !runt};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= HEAD;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= axis_tvalid && axis_tlast;
      if (axis_tvalid) state <= axis_tlast ? HEAD : BODY;
    end
  end

  always_ff @(posedge clk) begin
    if (axis_tvalid) begin
      flow_p0  <= cur_flow;
      match_p0 <= cur_match;
      total_p0 <= cur_total;
      hdr_p0   <= cur_hdr;
      pay_p0   <= cur_pay;
      keep_p0  <= cur_keep;
      if (axis_tlast) begin
        flow_p1  <= cur_flow;
        match_p1 <= cur_match;
        total_p1 <= cur_total;
        flags_p1 <= end_flags;
      end
    end
  end

  // Stage p1: commit the completed frame to the counters; a coincident clear discards it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int f = 0; f < N_FLOWS; f++) begin
        pkt_cnt[f]  <= '0;
        byte_cnt[f] <= '0;
        err_cnt[f]  <= '0;
      end
      unmatched_cnt <= '0;
      pkt_done      <= 1'b0;
      pkt_flow      <= '0;
      pkt_err_flags <= '0;
    end else begin
      pkt_done <= vld_p1 && match_p1;
      if (vld_p1 && match_p1) begin
        pkt_flow      <= flow_p1;
        pkt_err_flags <= flags_p1;
      end
      if (stat_clear) begin
        for (int f = 0; f < N_FLOWS; f++) begin
          pkt_cnt[f]  <= '0;
          byte_cnt[f] <= '0;
          err_cnt[f]  <= '0;
        end
        unmatched_cnt <= '0;
      end else if (vld_p1) begin
        if (match_p1) begin
          pkt_cnt[flow_p1]  <= sat_inc32(pkt_cnt[flow_p1]);
          byte_cnt[flow_p1] <= sat_add48(byte_cnt[flow_p1], total_p1);
          if (flags_p1 != 5'd0) err_cnt[flow_p1] <= sat_inc32(err_cnt[flow_p1]);
        end else begin
          unmatched_cnt <= sat_inc32(unmatched_cnt);
        end
      end
    end
  end

  always_comb begin
    stat_pkt_count  = '0;
    stat_byte_count = '0;
    stat_err_count  = '0;
    if (int'(stat_sel) < N_FLOWS) begin
      stat_pkt_count  = pkt_cnt[stat_sel];
      stat_byte_count = byte_cnt[stat_sel];
      stat_err_count  = err_cnt[stat_sel];
    end
  end

  assign stat_unmatched = unmatched_cnt;

endmodule

// File: tb/tb_packet_monitor.sv
// Bench for packet_monitor: directed frames plus randomized traffic, checked every
// cycle against a frame-level behavioural model of the classifier and counters.
module tb_packet_monitor;
  localparam int DW = 512;
  localparam int KW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          axis_tvalid;
  logic          axis_tlast;
  logic [KW-1:0] axis_tkeep;
  logic [DW-1:0] axis_tdata;
  logic          stat_clear;
  logic [1:0]    stat_sel;
  logic [31:0]   stat_pkt_count;
  logic [47:0]   stat_byte_count;
  logic [31:0]   stat_err_count;
  logic [31:0]   stat_unmatched;
  logic          pkt_done;
  logic [1:0]    pkt_flow;
  logic [4:0]    pkt_err_flags;

  packet_monitor dut (
    .clk(clk), .rst(rst), .axis_tvalid(axis_tvalid), .axis_tlast(axis_tlast),
    .axis_tkeep(axis_tkeep), .axis_tdata(axis_tdata), .stat_clear(stat_clear),
    .stat_sel(stat_sel), .stat_pkt_count(stat_pkt_count), .stat_byte_count(stat_byte_count),
    .stat_err_count(stat_err_count), .stat_unmatched(stat_unmatched), .pkt_done(pkt_done),
    .pkt_flow(pkt_flow), .pkt_err_flags(pkt_err_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    bit         matched;
    int         flow;
    logic [4:0] flags;
    int         total;
  } exp_t;

  exp_t        eq[$];
  logic [47:0] dmac_tab [4] = '{48'hABCDEF000001, 48'hABCDEF000002, 48'hABCDEF000003, 48'hABCDEF000004};
  logic [47:0] smac_tab [4] = '{48'hBEEFBEEF0001, 48'hBEEFBEEF0002, 48'hBEEFBEEF0003, 48'hBEEFBEEF0004};
  logic [7:0]  fill_tab [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

  int     n_cmp = 0;
  int     n_fail = 0;
  int     cyc = 0;
  logic   rst_q = 1'b0;
  logic   clr_q = 1'b0;
  bit     chk_on = 1'b0;
  longint mp [4];
  longint mb [4];
  longint me [4];
  longint mu;

  logic [DW-1:0] fd [8];
  logic [KW-1:0] fk [8];
  int            fn;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
    clr_q <= stat_clear;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint satv(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  // Whole-frame view: flatten the beats into kept bytes and apply the frame rules directly.
  function automatic exp_t model_frame();
    exp_t          e;
    logic [DW-1:0] d0;
    logic [47:0]   dm;
    logic [47:0]   sm;
    logic [15:0]   et;
    int            total;
    int            pc;
    bit            kbad;
    bit            pbad;
    bit            hbad;
    bit            rn;
    d0 = fd[0];
    dm = '0;
    sm = '0;
    for (int i = 0; i < 6; i++) begin
      dm = (dm << 8) | {40'd0, d0[8*i +: 8]};
      sm = (sm << 8) | {40'd0, d0[8*(6+i) +: 8]};
    end
    et = {d0[8*12 +: 8], d0[8*13 +: 8]};
    e.matched = 1'b0;
    e.flow = 0;
    e.due = 0;
    for (int f = 3; f >= 0; f--) begin
      if (dm == dmac_tab[f]) begin
        e.matched = 1'b1;
        e.flow = f;
      end
    end
    total = 0;
    kbad = 1'b0;
    pbad = 1'b0;
    for (int b = 0; b < fn; b++) begin
      pc = $countones(fk[b]);
      total += pc;
      if (b != fn - 1) begin
        if (pc != KW) kbad = 1'b1;
      end else if (pc == 0 || {1'b0, fk[b]} != ((65'd1 << pc) - 65'd1)) begin
        kbad = 1'b1;
      end
      for (int k = 0; k < KW; k++) begin
        if (fk[b][k] && (b * KW + k >= 14) && fd[b][8*k +: 8] != fill_tab[e.flow]) pbad = 1'b1;
      end
    end
    if (total > 65535) total = 65535;
    hbad = (sm != smac_tab[e.flow]) || (et != 16'h0800);
    rn = (total < 14);
    e.flags = {kbad, rn, (total != 192), pbad && !rn, hbad && !rn};
    e.total = total;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_q) begin
      for (int f = 0; f < 4; f++) begin
        mp[f] = 0;
        mb[f] = 0;
        me[f] = 0;
      end
      mu = 0;
      eq.delete();
      chk_on = 1'b1;
      check("rst_done", {63'd0, pkt_done}, 64'd0);
      check("rst_flow", {62'd0, pkt_flow}, 64'd0);
      check("rst_flags", {59'd0, pkt_err_flags}, 64'd0);
    end else if (chk_on) begin
      if (eq.size() > 0 && eq[0].due == cyc) begin
        e = eq.pop_front();
        check("done", {63'd0, pkt_done}, {63'd0, e.matched});
        if (e.matched) begin
          check("flow", {62'd0, pkt_flow}, 64'(e.flow));
          check("flags", {59'd0, pkt_err_flags}, {59'd0, e.flags});
          mp[e.flow] = satv(mp[e.flow] + 1, 64'hFFFF_FFFF);
          mb[e.flow] = satv(mb[e.flow] + e.total, 64'hFFFF_FFFF_FFFF);
          if (e.flags != 5'd0) me[e.flow] = satv(me[e.flow] + 1, 64'hFFFF_FFFF);
        end else begin
          mu = satv(mu + 1, 64'hFFFF_FFFF);
        end
      end else begin
        check("idle_done", {63'd0, pkt_done}, 64'd0);
      end
      if (clr_q) begin
        for (int f = 0; f < 4; f++) begin
          mp[f] = 0;
          mb[f] = 0;
          me[f] = 0;
        end
        mu = 0;
      end
    end
    if (chk_on) begin
      check("st_pkt", {32'd0, stat_pkt_count}, mp[stat_sel]);
      check("st_byte", {16'd0, stat_byte_count}, mb[stat_sel]);
      check("st_err", {32'd0, stat_err_count}, me[stat_sel]);
      check("st_unm", {32'd0, stat_unmatched}, mu);
    end
  end

  task automatic set_byte(input int pos, input logic [7:0] v);
    fd[pos / KW][8*(pos % KW) +: 8] = v;
  endtask

  task automatic build(input logic [47:0] dm, input int flow, input int len);
    fn = (len + KW - 1) / KW;
    for (int b = 0; b < 8; b++) begin
      fd[b] = {KW{fill_tab[flow]}};
      fk[b] = '1;
    end
    if (len % KW != 0) fk[fn-1] = (64'd1 << (len % KW)) - 64'd1;
    for (int i = 0; i < 6; i++) begin
      set_byte(i, dm[47-8*i -: 8]);
      set_byte(6 + i, smac_tab[flow][47-8*i -: 8]);
    end
    set_byte(12, 8'h08);
    set_byte(13, 8'h00);
  endtask

  task automatic rnd_ctrl();
    stat_sel = 2'($urandom_range(3, 0));
    stat_clear = ($urandom_range(99, 0) < 3);
  endtask

  task automatic send_frame(input int gap_max, input bit rnd);
    exp_t e;
    e = model_frame();
    for (int b = 0; b < fn; b++) begin
      int g;
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (g) begin
        axis_tvalid = 1'b0;
        axis_tlast = 1'b0;
        if (rnd) rnd_ctrl();
        @(posedge clk);
        #1;
      end
      axis_tvalid = 1'b1;
      axis_tdata = fd[b];
      axis_tkeep = fk[b];
      axis_tlast = (b == fn - 1);
      if (rnd) rnd_ctrl();
      if (b == fn - 1) begin
        e.due = cyc + 2;
        eq.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    axis_tvalid = 1'b0;
    axis_tlast = 1'b0;
    if (rnd) stat_clear = 1'b0;
  endtask

  task automatic lit_done(input bit done, input int flow, input logic [4:0] flags);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("lit_done", {63'd0, pkt_done}, {63'd0, done});
    if (done) begin
      check("lit_flow", {62'd0, pkt_flow}, 64'(flow));
      check("lit_flags", {59'd0, pkt_err_flags}, {59'd0, flags});
    end
  endtask

  task automatic lit_stats(input int sel, input longint p, input longint by, input longint er);
    @(posedge clk);
    #1;
    stat_sel = 2'(sel);
    #2;
    check("lit_pkt", {32'd0, stat_pkt_count}, p);
    check("lit_byte", {16'd0, stat_byte_count}, by);
    check("lit_err", {32'd0, stat_err_count}, er);
  endtask

  task automatic clear_stats();
    stat_clear = 1'b1;
    @(posedge clk);
    #1;
    stat_clear = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, got running, want finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    axis_tvalid = 1'b0;
    axis_tlast = 1'b0;
    axis_tkeep = '0;
    axis_tdata = '0;
    stat_clear = 1'b0;
    stat_sel = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    lit_stats(0, 0, 0, 0);
    check("lit_unm0", {32'd0, stat_unmatched}, 64'd0);

    // Clean flow-1 frame, three full beats.
    build(dmac_tab[1], 1, 192);
    send_frame(0, 0);
    lit_done(1'b1, 1, 5'b00000);
    lit_stats(1, 1, 192, 0);

    // Payload byte 100 corrupted.
    clear_stats();
    build(dmac_tab[1], 1, 192);
    set_byte(100, 8'h00);
    send_frame(0, 0);
    lit_done(1'b1, 1, 5'b00010);
    lit_stats(1, 1, 192, 1);

    // Short flow-0 frame: 64 + 64 + 16 bytes.
    clear_stats();
    build(dmac_tab[0], 0, 144);
    send_frame(0, 0);
    lit_done(1'b1, 0, 5'b00100);
    lit_stats(0, 1, 144, 1);

    // Unknown destination MAC.
    clear_stats();
    build(48'h000000000000, 0, 192);
    send_frame(0, 0);
    lit_done(1'b0, 0, 5'b00000);
    for (int f = 0; f < 4; f++) lit_stats(f, 0, 0, 0);
    check("lit_unm1", {32'd0, stat_unmatched}, 64'd1);

    // Reset lands on beat 2 of a flow-2 frame, then a clean flow-3 frame.
    build(dmac_tab[2], 2, 192);
    for (int b = 0; b < 2; b++) begin
      axis_tvalid = 1'b1;
      axis_tdata = fd[b];
      axis_tkeep = fk[b];
      axis_tlast = 1'b0;
      @(posedge clk);
      #1;
    end
    axis_tdata = fd[2];
    axis_tkeep = fk[2];
    axis_tlast = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    axis_tvalid = 1'b0;
    axis_tlast = 1'b0;
    build(dmac_tab[3], 3, 192);
    send_frame(0, 0);
    lit_done(1'b1, 3, 5'b00000);
    lit_stats(3, 1, 192, 0);
    lit_stats(2, 0, 0, 0);

    // Clear on the very edge the counters would update.
    build(dmac_tab[0], 0, 192);
    send_frame(0, 0);
    stat_clear = 1'b1;
    @(posedge clk);
    #1;
    stat_clear = 1'b0;
    for (int f = 0; f < 4; f++) lit_stats(f, 0, 0, 0);
    check("lit_unm2", {32'd0, stat_unmatched}, 64'd0);

    // Back-to-back frames, header beat right after tlast.
    build(dmac_tab[1], 1, 192);
    send_frame(0, 0);
    build(dmac_tab[2], 2, 130);
    send_frame(0, 0);
    repeat (3) @(posedge clk);
    lit_stats(1, 1, 192, 0);
    lit_stats(2, 1, 130, 1);

    // Randomized traffic.
    for (int n = 0; n < 80; n++) begin
      int          r;
      int          flow;
      int          len;
      int          kb;
      logic [47:0] dm;
      r = $urandom_range(99, 0);
      flow = $urandom_range(3, 0);
      dm = (r < 10) ? {16'($urandom), 32'($urandom)} : dmac_tab[flow];
      len = ($urandom_range(2, 0) != 0) ? 192 : int'($urandom_range(300, 1));
      build(dm, flow, len);
      if ($urandom_range(99, 0) < 20) set_byte($urandom_range(len - 1, 0), 8'($urandom));
      if ($urandom_range(99, 0) < 10) set_byte(6 + $urandom_range(5, 0), 8'($urandom));
      if ($urandom_range(99, 0) < 10) begin
        kb = $urandom_range(KW - 1, 0);
        if (fn > 1) fk[0][kb] = 1'b0;
        else fk[0][kb] = ~fk[0][kb];
      end
      send_frame(($urandom_range(99, 0) < 30) ? 0 : 2, 1'b1);
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    check("drain", 64'(eq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
